// File: rtl/one_wire_pkg.sv
// Shared constants for the 1-wire temperature sequencer: slave register map, status bits, commands, FSM codes.
// NBYTES grows from 2 to 9 when ONE_WIRE_CRC_EN is defined.
package one_wire_pkg;

  localparam logic [3:0] ADDR_STATUS = 4'd0;
  localparam logic [3:0] ADDR_TXRX   = 4'd1;
  localparam logic [3:0] ADDR_RXDATA = 4'd2;

  localparam int ST_BUSY  = 0;
  localparam int ST_NODEV = 1;
  localparam int ST_LINE  = 2;

  localparam logic [7:0] CMD_SKIP_ROM  = 8'hCC;
  localparam logic [7:0] CMD_CONVERT_T = 8'h44;
  localparam logic [7:0] CMD_READ_SP   = 8'hBE;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_RST1  = 4'd1;
  localparam logic [3:0] S_SKIP1 = 4'd2;
  localparam logic [3:0] S_CONV  = 4'd3;
  localparam logic [3:0] S_WAITC = 4'd4;
  localparam logic [3:0] S_RST2  = 4'd5;
  localparam logic [3:0] S_SKIP2 = 4'd6;
  localparam logic [3:0] S_RDCMD = 4'd7;
  localparam logic [3:0] S_RDB   = 4'd8;
  localparam logic [3:0] S_GET   = 4'd9;
  localparam logic [3:0] S_POLL  = 4'd10;
  localparam logic [3:0] S_DONE  = 4'd11;
  localparam logic [3:0] S_ERR   = 4'd12;

`ifdef ONE_WIRE_CRC_EN
  localparam logic [3:0] NBYTES = 4'd9;
`else
  localparam logic [3:0] NBYTES = 4'd2;
`endif

  // Dallas/Maxim CRC8 (x^8+x^5+x^4+1), reflected form, one byte LSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 8'h8C;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/one_wire_crc8.sv
// Byte-serial Dallas CRC8 accumulator; one byte per enabled cycle, result valid the cycle after.
// clr has priority over en; no backpressure.
module one_wire_crc8
  import one_wire_pkg::*;
(
  input  logic       s_clock,
  input  logic       s_reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  always_ff @(posedge s_clock or negedge s_reset) begin
    if (!s_reset)  crc <= 8'h00;
    else if (clr)  crc <= 8'h00;
    else if (en)   crc <= crc8_step(crc, data);
  end

endmodule

// File: rtl/one_wire_temp_sequencer.sv
// Avalon master running reset/SkipROM/ConvertT/wait/reset/SkipROM/ReadScratchpad on the 1-wire slave.
// Each access holds until m_waitrequest drops; ONE_WIRE_CRC_EN adds a 9-byte read with CRC8 check.
module one_wire_temp_sequencer
  import one_wire_pkg::*;
#(
  parameter int sysclock = 66666667,
  parameter int CONV_MS  = 750
) (
  input  logic        s_clock,
  input  logic        s_reset,
  input  logic        start,
  output logic        busy,
  output logic [15:0] temperature,
  output logic        valid,
  output logic        error,
  output logic [3:0]  m_address,
  output logic [7:0]  m_writedata,
  input  logic [7:0]  m_readdata,
  output logic        m_read,
  output logic        m_write,
  output logic        m_chipselect,
  input  logic        m_waitrequest
);

  localparam logic [31:0] CONV_TC = 32'(sysclock / 1000 * CONV_MS - 1);

  logic [3:0]  state, poll_ret, ret_next;
  logic        poll_chk, chk_next;
  logic [31:0] conv_cnt;
  logic [3:0]  byte_cnt;
  logic [7:0]  b0, b1;
  logic        acc_state, acc_wr, acc_on, acc_done;
  logic [3:0]  acc_addr;
  logic [7:0]  acc_dat;
  logic        crc_ok;
  logic        last_byte;

  assign busy      = (state != S_IDLE);
  assign acc_on    = m_read | m_write;
  assign acc_done  = acc_on & ~m_waitrequest;
  assign last_byte = (byte_cnt == NBYTES - 4'd1);

  // Per-state bus access and where POLL should return once the slave goes idle.
  always_comb begin
    acc_state = 1'b1;
    acc_wr    = 1'b0;
    acc_addr  = ADDR_STATUS;
    acc_dat   = 8'h00;
    ret_next  = S_IDLE;
    chk_next  = 1'b0;
    case (state)
      S_RST1:  begin acc_wr = 1'b1; ret_next = S_SKIP1; chk_next = 1'b1; end
      S_RST2:  begin acc_wr = 1'b1; ret_next = S_SKIP2; chk_next = 1'b1; end
      S_SKIP1: begin acc_wr = 1'b1; acc_addr = ADDR_TXRX; acc_dat = CMD_SKIP_ROM;  ret_next = S_CONV;  end
      S_CONV:  begin acc_wr = 1'b1; acc_addr = ADDR_TXRX; acc_dat = CMD_CONVERT_T; ret_next = S_WAITC; end
      S_SKIP2: begin acc_wr = 1'b1; acc_addr = ADDR_TXRX; acc_dat = CMD_SKIP_ROM;  ret_next = S_RDCMD; end
      S_RDCMD: begin acc_wr = 1'b1; acc_addr = ADDR_TXRX; acc_dat = CMD_READ_SP;   ret_next = S_RDB;   end
      S_RDB:   begin acc_addr = ADDR_TXRX; ret_next = S_GET; end
      S_GET:   acc_addr = ADDR_RXDATA;
      S_POLL:  acc_addr = ADDR_STATUS;
      default: acc_state = 1'b0;
    endcase
  end

`ifdef ONE_WIRE_CRC_EN
  logic [7:0] crc_val;

  one_wire_crc8 u_crc (
    .s_clock (s_clock),
    .s_reset (s_reset),
    .clr     ((state == S_RDCMD) && acc_done),
    .en      ((state == S_GET) && acc_done && !last_byte),
    .data    (m_readdata),
    .crc     (crc_val)
  );

  assign crc_ok = (m_readdata == crc_val);
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge s_clock or negedge s_reset) begin
    if (!s_reset) begin
      state        <= S_IDLE;
      poll_ret     <= S_IDLE;
      poll_chk     <= 1'b0;
      conv_cnt     <= 32'd0;
      byte_cnt     <= 4'd0;
      b0           <= 8'h00;
      b1           <= 8'h00;
      temperature  <= 16'h0000;
      valid        <= 1'b0;
      error        <= 1'b0;
      m_address    <= 4'd0;
      m_writedata  <= 8'h00;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_chipselect <= 1'b0;
    end else begin
      valid <= 1'b0;

      // Strobes drop after completion, so back-to-back accesses always get one idle cycle.
      if (acc_state && !acc_on) begin
        m_chipselect <= 1'b1;
        m_read       <= ~acc_wr;
        m_write      <= acc_wr;
        m_address    <= acc_addr;
        m_writedata  <= acc_dat;
      end else if (acc_done) begin
        m_chipselect <= 1'b0;
        m_read       <= 1'b0;
        m_write      <= 1'b0;
        m_address    <= 4'd0;
        m_writedata  <= 8'h00;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            error <= 1'b0;
            state <= S_RST1;
          end
        end
        S_WAITC: begin
          if (conv_cnt == CONV_TC) begin
            conv_cnt <= 32'd0;
            state    <= S_RST2;
          end else begin
            conv_cnt <= conv_cnt + 32'd1;
          end
        end
        S_POLL: begin
          if (acc_done && !m_readdata[ST_BUSY])
            state <= (poll_chk && m_readdata[ST_NODEV]) ? S_ERR : poll_ret;
        end
        S_GET: begin
          if (acc_done) begin
            if (byte_cnt == 4'd0) b0 <= m_readdata;
            if (byte_cnt == 4'd1) b1 <= m_readdata;
            byte_cnt <= byte_cnt + 4'd1;
            if (last_byte) state <= crc_ok ? S_DONE : S_ERR;
            else           state <= S_RDB;
          end
        end
        S_DONE: begin
          temperature <= {b1, b0};
          valid       <= 1'b1;
          state       <= S_IDLE;
        end
        S_ERR: begin
          error <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          if (acc_done) begin
            state    <= S_POLL;
            poll_ret <= ret_next;
            poll_chk <= chk_next;
            if (state == S_RDCMD) byte_cnt <= 4'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_one_wire_temp_sequencer.sv
// Directed bench for one_wire_temp_sequencer with a behavioural 1-wire slave; honours ONE_WIRE_CRC_EN.
module tb_one_wire_temp_sequencer;

`ifdef ONE_WIRE_CRC_EN
  localparam int NB = 9;
  localparam logic [15:0] EXP_T = 16'h0550;
`else
  localparam int NB = 2;
  localparam logic [15:0] EXP_T = 16'h0191;
`endif
  localparam int EXP_ACC = 3 * (6 + NB) + NB;

  logic        s_clock = 1'b0;
  logic        s_reset;
  logic        start;
  logic        busy;
  logic [15:0] temperature;
  logic        valid;
  logic        error;
  logic [3:0]  m_address;
  logic [7:0]  m_writedata;
  logic [7:0]  m_readdata = 8'h00;
  logic        m_read;
  logic        m_write;
  logic        m_chipselect;
  logic        m_waitrequest = 1'b0;

  one_wire_temp_sequencer #(.sysclock(100000), .CONV_MS(1)) dut (
    .s_clock       (s_clock),
    .s_reset       (s_reset),
    .start         (start),
    .busy          (busy),
    .temperature   (temperature),
    .valid         (valid),
    .error         (error),
    .m_address     (m_address),
    .m_writedata   (m_writedata),
    .m_readdata    (m_readdata),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_chipselect  (m_chipselect),
    .m_waitrequest (m_waitrequest)
  );

  always #5 s_clock = ~s_clock;

  int compared = 0;
  int mismatched = 0;

  // Slave model state (written only by the slave process).
  int          stall_cnt = 0, busy_polls = 0, acc_count = 0, tx_cnt = 0;
  int          rx_idx = 0, rdslot_cnt = 0, stab_viol = 0, valid_cnt = 0;
  logic        held = 1'b0;
  logic [14:0] held_vec = '0;
  logic [7:0]  tx_log [0:63];
  // Knobs (written only by the stimulus process).
  int          stall_cycles = 0;
  logic        nodev = 1'b0;
  logic [7:0]  sp [0:8];

  // Decides waitrequest on the falling edge; an access completes at the following rising edge.
  always @(negedge s_clock) begin
    if (!s_reset) begin
      m_waitrequest = 1'b0;
      stall_cnt = 0;
      busy_polls = 0;
      held = 1'b0;
    end else begin
      if (held && ({m_chipselect, m_read, m_write, m_address, m_writedata} !== held_vec))
        stab_viol++;
      held = 1'b0;
      if (m_chipselect && (m_read || m_write)) begin
        if (stall_cnt < stall_cycles) begin
          m_waitrequest = 1'b1;
          stall_cnt++;
          held = 1'b1;
          held_vec = {m_chipselect, m_read, m_write, m_address, m_writedata};
        end else begin
          m_waitrequest = 1'b0;
          stall_cnt = 0;
          acc_count++;
          if (m_write) begin
            busy_polls = 1;
            if (m_address == 4'd1) begin
              if (tx_cnt < 64) tx_log[tx_cnt] = m_writedata;
              tx_cnt++;
              if (m_writedata == 8'hBE) rx_idx = 0;
            end
          end else begin
            case (m_address)
              4'd0: begin
                m_readdata = {5'b0, 1'b0, nodev, (busy_polls > 0)};
                if (busy_polls > 0) busy_polls--;
              end
              4'd1: begin
                busy_polls = 1;
                rdslot_cnt++;
              end
              4'd2: begin
                m_readdata = (rx_idx < 9) ? sp[rx_idx] : 8'h00;
                rx_idx++;
              end
              default: m_readdata = 8'h00;
            endcase
          end
        end
      end else begin
        m_waitrequest = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  always @(negedge s_clock) if (valid === 1'b1) valid_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge s_clock);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 4000) begin
      tick;
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic load_sp(input logic bad_crc);
    for (int i = 0; i < 9; i++) sp[i] = 8'h00;
`ifdef ONE_WIRE_CRC_EN
    sp[0] = 8'h50; sp[1] = 8'h05; sp[2] = 8'h4B; sp[3] = 8'h46; sp[4] = 8'h7F;
    sp[5] = 8'hFF; sp[6] = 8'h0C; sp[7] = 8'h10; sp[8] = bad_crc ? 8'h1D : 8'h1C;
`else
    sp[0] = 8'h91; sp[1] = 8'h01;
    if (bad_crc) sp[8] = 8'hFF;
`endif
  endtask

  initial begin
    int tb0, v0, a0, s0, r0, n;
    s_reset = 1'b0;
    start = 1'b0;
    load_sp(1'b0);
    repeat (3) tick;

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_temp", {16'd0, temperature}, 32'd0);
    check("rst_bus", {m_chipselect, m_read, m_write, m_address, m_writedata}, 32'd0);
    s_reset = 1'b1;
    tick;

    // Nominal read
    tb0 = tx_cnt; v0 = valid_cnt;
    pulse_start;
    check("nom_busy", {31'd0, busy}, 32'd1);
    wait_idle("nom_timeout");
    check("nom_txn", tx_cnt - tb0, 32'd4);
    check("nom_tx0", tx_log[tb0],     32'hCC);
    check("nom_tx1", tx_log[tb0 + 1], 32'h44);
    check("nom_tx2", tx_log[tb0 + 2], 32'hCC);
    check("nom_tx3", tx_log[tb0 + 3], 32'hBE);
    check("nom_temp", {16'd0, temperature}, {16'd0, EXP_T});
    check("nom_valid", valid_cnt - v0, 32'd1);
    check("nom_error", {31'd0, error}, 32'd0);

    // No device present
    nodev = 1'b1;
    tb0 = tx_cnt; v0 = valid_cnt;
    pulse_start;
    wait_idle("nodev_timeout");
    check("nodev_error", {31'd0, error}, 32'd1);
    check("nodev_valid", valid_cnt - v0, 32'd0);
    check("nodev_temp", {16'd0, temperature}, {16'd0, EXP_T});
    check("nodev_txn", tx_cnt - tb0, 32'd0);
    nodev = 1'b0;

    // Waitrequest stalls on every access
    stall_cycles = 5;
    a0 = acc_count; s0 = stab_viol; v0 = valid_cnt;
    pulse_start;
    check("stall_errclr", {31'd0, error}, 32'd0);
    wait_idle("stall_timeout");
    check("stall_stable", stab_viol - s0, 32'd0);
    check("stall_acc", acc_count - a0, EXP_ACC);
    check("stall_temp", {16'd0, temperature}, {16'd0, EXP_T});
    check("stall_valid", valid_cnt - v0, 32'd1);
    stall_cycles = 0;

    // start during WAITC and coincident with DONE
    a0 = acc_count; v0 = valid_cnt; tb0 = tx_cnt;
    pulse_start;
    n = 0;
    while ((tx_cnt - tb0) < 2 && n < 2000) begin tick; n++; end
    check("ign_reach_conv", {31'd0, (tx_cnt - tb0) >= 2}, 32'd1);
    repeat (10) tick;
    pulse_start;
    n = 0;
    while ((tx_cnt - tb0) < 4 && n < 2000) begin tick; n++; end
    while (rx_idx != NB && n < 4000) begin tick; n++; end
    check("ign_reach_last", rx_idx, NB);
    tick;
    pulse_start;
    repeat (20) tick;
    check("ign_busy", {31'd0, busy}, 32'd0);
    check("ign_valid", valid_cnt - v0, 32'd1);
    check("ign_acc", acc_count - a0, EXP_ACC);
    check("ign_txn", tx_cnt - tb0, 32'd4);

    // Asynchronous reset during the byte-read phase
    r0 = rdslot_cnt;
    pulse_start;
    n = 0;
    while (rdslot_cnt == r0 && n < 2000) begin tick; n++; end
    check("mid_reach_rdb", {31'd0, rdslot_cnt != r0}, 32'd1);
    tick;
    #1 s_reset = 1'b0;
    #1;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_bus", {m_chipselect, m_read, m_write, m_address, m_writedata}, 32'd0);
    check("mid_temp", {16'd0, temperature}, 32'd0);
    check("mid_flags", {30'd0, valid, error}, 32'd0);
    tick;
    tick;
    s_reset = 1'b1;
    tick;
    v0 = valid_cnt;
    pulse_start;
    wait_idle("mid_timeout");
    check("mid_re_temp", {16'd0, temperature}, {16'd0, EXP_T});
    check("mid_re_valid", valid_cnt - v0, 32'd1);
    check("mid_re_error", {31'd0, error}, 32'd0);

`ifdef ONE_WIRE_CRC_EN
    // Corrupted CRC byte
    load_sp(1'b1);
    v0 = valid_cnt;
    pulse_start;
    wait_idle("crc_timeout");
    check("crc_error", {31'd0, error}, 32'd1);
    check("crc_valid", valid_cnt - v0, 32'd0);
    check("crc_temp", {16'd0, temperature}, {16'd0, EXP_T});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
